// File: rtl/ram_nxw_if.sv
// ram_nxw_if: request/ready access bus between a controller and ram_nxw.
// The controller drives request, read_write, address, data and init.
// The RAM returns ready, read_valid, saved_data and parity_error.
interface ram_nxw_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  logic                  request;
  logic                  read_write;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;
  logic                  init;
  logic                  ready;
  logic                  read_valid;
  logic [DATA_WIDTH-1:0] saved_data;
  logic                  parity_error;

  modport master (
    output request, read_write, address, data, init,
    input  ready, read_valid, saved_data, parity_error
  );

  modport slave (
    input  request, read_write, address, data, init,
    output ready, read_valid, saved_data, parity_error
  );
endinterface

// File: rtl/ram_nxw.sv
// ram_nxw: single-port synchronous RAM, DATA_WIDTH x 2**ADDR_WIDTH words.
// After clear is released, or when init is sampled while idle, a sweep
// writes zero to every word (one per cycle) before the block accepts
// requests. Reads are registered: saved_data and read_valid appear one
// cycle after the accepting edge.
// Optional feature macro: RAM_NXW_PARITY_EN adds one even-parity bit per
// word and reports a stored-parity mismatch on parity_error with each read.
module ram_nxw #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input logic         clock,
  input logic         clear,
  ram_nxw_if.slave    bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] counter, counter_next;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  read_valid_q;
  logic [DATA_WIDTH-1:0] saved_data_q;

  // State and sweep-counter register; clear restarts the sweep from word 0.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= SWEEP;
      counter <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      state   <= state_next;
      counter <= counter_next;
    end
  end

  // Next-state and memory-port decode; init wins over a same-cycle request.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_next   = state;
    counter_next = counter;
    wr_en        = 1'b0;
    wr_addr      = counter;
    wr_data      = '0;
    rd_en        = 1'b0;
    unique case (state)
      SWEEP: begin
        wr_en = 1'b1;
        if (counter == LAST_ADDR) begin
          state_next   = IDLE;
          counter_next = '0;
        end else begin
          counter_next = counter + 1'b1;
        end
      end
      IDLE: begin
        if (bus.init) begin
          state_next   = SWEEP;
          counter_next = '0;
        end else if (bus.request) begin
          if (bus.read_write) begin
            wr_en   = 1'b1;
            wr_addr = bus.address;
            wr_data = bus.data;
          end else begin
            rd_en = 1'b1;
          end
        end
      end
      default: state_next = SWEEP;
    endcase
  end

  // Storage array write port, shared by the sweep and host writes.
  always_ff @(posedge clock) begin
    // NOTE: the array has no reset; the zero-fill sweep after clear is what
    // gives it defined contents.
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read data and one-cycle valid strobe.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      read_valid_q <= 1'b0;
      saved_data_q <= '0;
    end else begin
      read_valid_q <= rd_en;
      if (rd_en) saved_data_q <= mem[bus.address];
    end
  end

`ifdef RAM_NXW_PARITY_EN
  logic [DEPTH-1:0] parity_mem;
  logic             parity_error_q;

  // Parity array write port; sweep stores parity of zero, i.e. 0.
  always_ff @(posedge clock) begin
    if (wr_en) parity_mem[wr_addr] <= ^wr_data;
  end

  // Parity check registered with the read; forced to 0 on non-read cycles.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      parity_error_q <= 1'b0;
    end else begin
      parity_error_q <= rd_en & (parity_mem[bus.address] ^ (^mem[bus.address]));
    end
  end

  assign bus.parity_error = parity_error_q;
`else
  assign bus.parity_error = 1'b0;
`endif

  assign bus.ready      = (state == IDLE);
  assign bus.read_valid = read_valid_q;
  assign bus.saved_data = saved_data_q;

endmodule

// File: tb/tb_ram_nxw.sv
// tb_ram_nxw: self-checking bench for ram_nxw (DATA_WIDTH=8, ADDR_WIDTH=2).
// Reads push expected data onto a scoreboard queue; a monitor pops and
// compares on every read_valid pulse. Scenario tasks check ready timing,
// reset behaviour and output holding inline.
module tb_ram_nxw;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
  } exp_t;

  logic clock;
  logic clear;

  ram_nxw_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_nxw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  int   checks   = 0;
  int   failures = 0;
  int   n_valid  = 0;
  exp_t sb[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (clear) begin
      if (bus.read_valid) begin
        exp_t e;
        n_valid++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_read_valid: actual=1 required=0 at %0t", $time);
        end else begin
          e = sb.pop_front();
          if (bus.saved_data !== e.data) begin
            failures++;
            $display("FAIL read_data: actual=%h required=%h at %0t", bus.saved_data, e.data, $time);
          end
          checks++;
          if (bus.parity_error !== e.perr) begin
            failures++;
            $display("FAIL read_parity: actual=%b required=%b at %0t", bus.parity_error, e.perr, $time);
          end
        end
      end else begin
        checks++;
        if (bus.parity_error !== 1'b0) begin
          failures++;
          $display("FAIL parity_idle: actual=%b required=0 at %0t", bus.parity_error, $time);
        end
      end
    end
  end

  // One access cycle, driven on the falling edge; reads register an expectation.
  task automatic access(input logic rw, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic perr = 1'b0);
    exp_t e;
    bus.request    = 1'b1;
    bus.read_write = rw;
    bus.address    = a;
    bus.data       = rw ? d : '0;
    if (!rw) begin
      e.data = d;
      e.perr = perr;
      sb.push_back(e);
    end
    @(negedge clock);
  endtask

  task automatic idle_cycle();
    bus.request    = 1'b0;
    bus.read_write = 1'b0;
    bus.init       = 1'b0;
    @(negedge clock);
  endtask

  // After clear release at a falling edge, ready must be 0 for DEPTH-1 samples then 1.
  task automatic expect_sweep_ready(input string tag);
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clock);
      checks++;
      if (bus.ready !== (i == DEPTH)) begin
        failures++;
        $display("FAIL %s_ready_edge%0d: actual=%b required=%b", tag, i, bus.ready, (i == DEPTH));
      end
    end
  endtask

  task automatic expect_outputs_zero(input string tag);
    checks++;
    if ({bus.ready, bus.read_valid, bus.saved_data, bus.parity_error} !== '0) begin
      failures++;
      $display("FAIL %s_outputs: actual ready=%b valid=%b data=%h perr=%b required all 0",
               tag, bus.ready, bus.read_valid, bus.saved_data, bus.parity_error);
    end
  endtask

  task automatic expect_drained(input string tag);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: actual pending=%0d required=0", tag, sb.size());
    end
  endtask

  task automatic test_reset();
    clear          = 1'b0;
    bus.request    = 1'b0;
    bus.read_write = 1'b0;
    bus.address    = '0;
    bus.data       = '0;
    bus.init       = 1'b0;
    #12;
    expect_outputs_zero("reset");
    @(negedge clock);
    clear = 1'b1;
    expect_sweep_ready("reset");
    for (int a = 0; a < DEPTH; a++) access(1'b0, AW'(a), 8'h00);
    idle_cycle();
    idle_cycle();
    expect_drained("reset_reads");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [DEPTH];
    int            v0;
    vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'hFF; vals[3] = 8'h01;
    for (int a = 0; a < DEPTH; a++) access(1'b1, AW'(a), vals[a]);
    v0 = n_valid;
    for (int a = DEPTH - 1; a >= 0; a--) access(1'b0, AW'(a), vals[a]);
    idle_cycle();
    idle_cycle();
    checks++;
    if (n_valid - v0 != DEPTH) begin
      failures++;
      $display("FAIL b2b_valid_count: actual=%0d required=%0d", n_valid - v0, DEPTH);
    end
    expect_drained("b2b");
  endtask

  task automatic test_write_then_read();
    access(1'b1, 2'd2, 8'h55);
    access(1'b0, 2'd2, 8'h55);
    access(1'b1, 2'd2, 8'h11);
    idle_cycle();
    checks++;
    if (bus.saved_data !== 8'h55 || bus.read_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_after_write: actual data=%h valid=%b required data=55 valid=0",
               bus.saved_data, bus.read_valid);
    end
    access(1'b0, 2'd2, 8'h11);
    idle_cycle();
    idle_cycle();
    expect_drained("wr_rd");
  endtask

  task automatic test_init_priority();
    for (int a = 0; a < DEPTH; a++) access(1'b1, AW'(a), DW'(8'h90 + a));
    // A read with init in the same cycle must not be accepted: no expectation pushed.
    bus.init       = 1'b1;
    bus.request    = 1'b1;
    bus.read_write = 1'b0;
    bus.address    = 2'd3;
    @(negedge clock);
    bus.init    = 1'b0;
    bus.request = 1'b0;
    checks++;
    if (bus.ready !== 1'b0 || bus.read_valid !== 1'b0) begin
      failures++;
      $display("FAIL init_priority: actual ready=%b valid=%b required ready=0 valid=0",
               bus.ready, bus.read_valid);
    end
    for (int i = 2; i <= DEPTH + 1; i++) begin
      @(negedge clock);
      checks++;
      if (bus.ready !== (i == DEPTH + 1)) begin
        failures++;
        $display("FAIL init_ready_cycle%0d: actual=%b required=%b", i, bus.ready, (i == DEPTH + 1));
      end
    end
    for (int a = 0; a < DEPTH; a++) access(1'b0, AW'(a), 8'h00);
    idle_cycle();
    idle_cycle();
    expect_drained("init");
  endtask

  task automatic test_clear_mid_access();
    access(1'b1, 2'd1, 8'h77);
    access(1'b0, 2'd1, 8'h77);
    // Second read is accepted, then clear drops its pending read_valid.
    bus.request    = 1'b1;
    bus.read_write = 1'b0;
    bus.address    = 2'd0;
    @(posedge clock);
    #2;
    clear       = 1'b0;
    bus.request = 1'b0;
    #1;
    expect_outputs_zero("clear_access");
    @(negedge clock);
    checks++;
    if (bus.read_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_drops_valid: actual=%b required=0", bus.read_valid);
    end
    sb.delete();
    clear = 1'b1;
    expect_sweep_ready("clear_access");
  endtask

  task automatic test_clear_mid_sweep();
    access(1'b1, 2'd3, 8'h42);
    access(1'b0, 2'd3, 8'h42);
    bus.request = 1'b0;
    bus.init    = 1'b1;
    @(negedge clock);
    bus.init = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    #1;
    expect_outputs_zero("clear_sweep");
    @(negedge clock);
    sb.delete();
    clear = 1'b1;
    expect_sweep_ready("clear_sweep");
    for (int a = 0; a < DEPTH; a++) access(1'b0, AW'(a), 8'h00);
    idle_cycle();
    idle_cycle();
    expect_drained("clear_sweep");
  endtask

`ifdef RAM_NXW_PARITY_EN
  task automatic test_parity();
    access(1'b1, 2'd1, 8'hA5);
    access(1'b1, 2'd0, 8'h3C);
    bus.request = 1'b0;
    dut.parity_mem[1] = ~dut.parity_mem[1];
    access(1'b0, 2'd1, 8'hA5, 1'b1);
    access(1'b0, 2'd0, 8'h3C, 1'b0);
    idle_cycle();
    idle_cycle();
    expect_drained("parity");
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_write_then_read();
    test_init_priority();
    test_clear_mid_access();
    test_clear_mid_sweep();
`ifdef RAM_NXW_PARITY_EN
    test_parity();
`endif
    idle_cycle();
    expect_drained("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
